// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment driver: hex decode, leading-zero blanking,
// dead-time digit scanning and a load path that only updates the display between frames.
module seven_segment_scan #(
  parameter int DIGITS        = 4,
  parameter int CLK_DIV       = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  ready,
  output logic [6:0]            hex0,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int TCW = $clog2(CLK_DIV);
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  D_LAST  = DW'(DIGITS - 1);
  localparam logic           POL     = (ACTIVE_LOW != 0);

  logic [TCW-1:0]      tc_reg, tc_next;
  logic [DW-1:0]       d_reg, d_next;
  logic [4*DIGITS-1:0] shadow_reg, shadow_next;
  logic [DIGITS-1:0]   shdp_reg, shdp_next;
  logic [4*DIGITS-1:0] pend_reg, pend_next;
  logic [DIGITS-1:0]   pdp_reg, pdp_next;
  logic                pflag_reg, pflag_next;
  logic                wrapped_reg;
  logic [6:0]          hex0_reg;
  logic                dp_reg;
  logic [DIGITS-1:0]   an_reg;
  logic                frame_done_reg;

  logic                tc_term, wrap, dead;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS:1]     zero_above;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   onehot;
  logic [6:0]          seg_ah;
  logic [DIGITS-1:0]   an_ah;
  logic                dp_ah;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign tc_term = (tc_reg == TC_LAST);
  assign wrap    = tc_term && (d_reg == D_LAST);
  assign dead    = (tc_reg == '0);

  // zero_above[i] is true when nibble i and every higher nibble are zero
  assign zero_above[DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]    = shadow_reg[4*gi +: 4];
      assign onehot[gi] = (d_reg == DW'(gi));
      if (gi == 0) begin : g_first
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign zero_above[gi] = zero_above[gi+1] && (nib[gi] == 4'h0);
        assign blank[gi]      = (BLANK_LEADING != 0) && zero_above[gi];
      end
    end
  endgenerate

  always_comb begin
    tc_next = tc_term ? '0 : tc_reg + 1'b1;
    d_next  = d_reg;
    if (tc_term) begin
      d_next = (d_reg == D_LAST) ? '0 : d_reg + 1'b1;
    end
  end

  // Pending data is only ever copied into the shadow on the wrap cycle
  always_comb begin
    shadow_next = shadow_reg;
    shdp_next   = shdp_reg;
    pend_next   = pend_reg;
    pdp_next    = pdp_reg;
    pflag_next  = pflag_reg;
    if (wrap) begin
      if (load) begin
        shadow_next = value;
        shdp_next   = dp_in;
      end else if (pflag_reg) begin
        shadow_next = pend_reg;
        shdp_next   = pdp_reg;
      end
      pflag_next = 1'b0;
    end else if (load) begin
      pend_next  = value;
      pdp_next   = dp_in;
      pflag_next = 1'b1;
    end
  end

  always_comb begin
    seg_ah = '0;
    dp_ah  = 1'b0;
    an_ah  = '0;
    if (!dead) begin
      seg_ah = blank[d_reg] ? 7'b0000000 : seg_decode(nib[d_reg]);
      dp_ah  = shdp_reg[d_reg];
      an_ah  = onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_reg         <= '0;
      d_reg          <= '0;
      shadow_reg     <= '0;
      shdp_reg       <= '0;
      pend_reg       <= '0;
      pdp_reg        <= '0;
      pflag_reg      <= 1'b0;
      wrapped_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      hex0_reg       <= {7{POL}};
      dp_reg         <= POL;
      an_reg         <= {DIGITS{POL}};
    end else begin
      tc_reg         <= tc_next;
      d_reg          <= d_next;
      shadow_reg     <= shadow_next;
      shdp_reg       <= shdp_next;
      pend_reg       <= pend_next;
      pdp_reg        <= pdp_next;
      pflag_reg      <= pflag_next;
      // one extra stage so the pulse lines up with digit 0's dead cycle
      wrapped_reg    <= wrap;
      frame_done_reg <= wrapped_reg;
      hex0_reg       <= seg_ah ^ {7{POL}};
      dp_reg         <= dp_ah ^ POL;
      an_reg         <= an_ah ^ {DIGITS{POL}};
    end
  end

  assign ready      = ~pflag_reg;
  assign hex0       = hex0_reg;
  assign dp         = dp_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: four parameterisations share one stimulus bus;
// expected per-cycle outputs are queued and compared as each cycle completes.
module tb_seven_segment_scan;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic       rdy0, rdy1, rdy2, rdy3;
  logic [6:0] hex_0, hex_1, hex_2, hex_3;
  logic       dp0, dp1, dp2, dp3;
  logic [3:0] an0, an2, an3;
  logic [0:0] an1;
  logic       fd0, fd1, fd2, fd3;

  seven_segment_scan #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1), .BLANK_LEADING(1)) u0 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .ready(rdy0), .hex0(hex_0), .dp(dp0), .an(an0), .frame_done(fd0));
  seven_segment_scan #(.DIGITS(1), .CLK_DIV(2), .ACTIVE_LOW(1), .BLANK_LEADING(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .value(value[3:0]), .dp_in(dp_in[0:0]),
    .ready(rdy1), .hex0(hex_1), .dp(dp1), .an(an1), .frame_done(fd1));
  seven_segment_scan #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1), .BLANK_LEADING(0)) u2 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .ready(rdy2), .hex0(hex_2), .dp(dp2), .an(an2), .frame_done(fd2));
  seven_segment_scan #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0), .BLANK_LEADING(1)) u3 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .ready(rdy3), .hex0(hex_3), .dp(dp3), .an(an3), .frame_done(fd3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0] hex;
    logic       dp;
    logic [3:0] an;
    logic       fd;
    string      tag;
  } exp_t;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] hex;
  } vec_t;

  int cfg_dg [4] = '{4, 1, 4, 4};
  int cfg_cd [4] = '{4, 2, 4, 4};
  int cfg_al [4] = '{1, 1, 1, 0};
  int cfg_bl [4] = '{1, 1, 0, 1};

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  exp_t  sb[$];
  vec_t  vecs[16];
  int    sel;
  string cur_test;
  int    chk_cnt;
  int    pass_cnt;

  logic [6:0] obs_hex;
  logic       obs_dp;
  logic [3:0] obs_an;
  logic       obs_fd;
  logic       obs_ready;

  always_comb begin
    obs_hex = hex_0; obs_dp = dp0; obs_an = an0; obs_fd = fd0; obs_ready = rdy0;
    case (sel)
      1: begin obs_hex = hex_1; obs_dp = dp1; obs_an = {3'b000, an1}; obs_fd = fd1; obs_ready = rdy1; end
      2: begin obs_hex = hex_2; obs_dp = dp2; obs_an = an2; obs_fd = fd2; obs_ready = rdy2; end
      3: begin obs_hex = hex_3; obs_dp = dp3; obs_an = an3; obs_fd = fd3; obs_ready = rdy3; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) begin
      pass_cnt++;
      $display("ok   %s got=%0h", name, got);
    end else begin
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Expected outputs for cycle j of a frame displaying v/p, derived from slot position
  function automatic exp_t mk_rec(input int s, input logic [15:0] v, input logic [3:0] p,
                                  input int j, input bit fdf);
    exp_t r;
    int dig, t;
    logic [6:0] h;
    logic pd;
    logic [3:0] a, mask;
    logic [15:0] upper;
    dig = j / cfg_cd[s];
    t   = j % cfg_cd[s];
    h = '0; pd = 1'b0; a = '0;
    if (t != 0) begin
      upper = v >> (4 * dig);
      a  = 4'(1 << dig);
      pd = p[dig];
      if (cfg_bl[s] != 0 && dig > 0 && upper == 16'h0) h = '0;
      else h = seg_tab[upper[3:0]];
    end
    mask = 4'((1 << cfg_dg[s]) - 1);
    if (cfg_al[s] != 0) begin
      h = ~h; pd = ~pd; a = ~a & mask;
    end
    r.hex = h; r.dp = pd; r.an = a; r.fd = (j == 0) && fdf;
    r.tag = $sformatf("%s j=%0d", cur_test, j);
    return r;
  endfunction

  function automatic exp_t off_rec(input int s);
    exp_t r;
    r.hex = (cfg_al[s] != 0) ? 7'h7F : 7'h00;
    r.dp  = (cfg_al[s] != 0);
    r.an  = (cfg_al[s] != 0) ? 4'((1 << cfg_dg[s]) - 1) : 4'h0;
    r.fd  = 1'b0;
    r.tag = {cur_test, " off"};
    return r;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, {19'b0, obs_hex, obs_dp, obs_an, obs_fd}, {19'b0, e.hex, e.dp, e.an, e.fd});
    end
  endtask

  task automatic do_reset(input int s);
    sel = s;
    rst = 1'b1;
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(off_rec(s));
      step();
    end
    check({cur_test, " ready in reset"}, {31'b0, obs_ready}, 32'd1);
    rst = 1'b0;
  endtask

  // Run nsteps cycles of a frame showing dv/dpv; optional loads at frame positions j1/j2
  task automatic run_frame(input int s, input logic [15:0] dv, input logic [3:0] dpv,
                           input bit fdf, input int nsteps,
                           input int j1, input logic [15:0] v1, input logic [3:0] p1,
                           input int j2, input logic [15:0] v2, input logic [3:0] p2);
    int n;
    n = cfg_dg[s] * cfg_cd[s];
    for (int j = 0; j < nsteps; j++) sb.push_back(mk_rec(s, dv, dpv, j, fdf));
    for (int j = 0; j < nsteps; j++) begin
      load = 1'b0;
      if (j == j1) begin load = 1'b1; value = v1; dp_in = p1; end
      if (j == j2) begin load = 1'b1; value = v2; dp_in = p2; end
      step();
      if (j == j1 || j == j2)
        check($sformatf("%s ready after load j=%0d", cur_test, j), {31'b0, obs_ready},
              (j == n - 1) ? 32'd1 : 32'd0);
    end
    load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    chk_cnt = 0; pass_cnt = 0; sel = 0;
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    vecs[0]  = '{4'h0, 7'b0000001}; vecs[1]  = '{4'h1, 7'b1001111};
    vecs[2]  = '{4'h2, 7'b0010010}; vecs[3]  = '{4'h3, 7'b0000110};
    vecs[4]  = '{4'h4, 7'b1001100}; vecs[5]  = '{4'h5, 7'b0100100};
    vecs[6]  = '{4'h6, 7'b0100000}; vecs[7]  = '{4'h7, 7'b0001111};
    vecs[8]  = '{4'h8, 7'b0000000}; vecs[9]  = '{4'h9, 7'b0000100};
    vecs[10] = '{4'hA, 7'b0001000}; vecs[11] = '{4'hB, 7'b1100000};
    vecs[12] = '{4'hC, 7'b0110001}; vecs[13] = '{4'hD, 7'b1000010};
    vecs[14] = '{4'hE, 7'b0110000}; vecs[15] = '{4'hF, 7'b0111000};

    // Reset, first digit, blanking and tear-free loads on the 4-digit active-low unit
    cur_test = "reset";
    do_reset(0);
    run_frame(0, 16'h0000, 4'h0, 1'b0, 16, -1, 0, 0, -1, 0, 0);
    cur_test = "blank";
    run_frame(0, 16'h0000, 4'h0, 1'b1, 16, 3, 16'h0050, 4'h0, -1, 0, 0);
    run_frame(0, 16'h0050, 4'h0, 1'b1, 16, 5, 16'h0050, 4'h8, -1, 0, 0);
    run_frame(0, 16'h0050, 4'h8, 1'b1, 16, 4, 16'h0000, 4'h0, -1, 0, 0);
    cur_test = "tearfree";
    run_frame(0, 16'h0000, 4'h0, 1'b1, 16, 2, 16'hAAAA, 4'h0, 9, 16'h5555, 4'h0);
    run_frame(0, 16'h5555, 4'h0, 1'b1, 16, 15, 16'h1234, 4'h1, -1, 0, 0);
    run_frame(0, 16'h1234, 4'h1, 1'b1, 16, -1, 0, 0, -1, 0, 0);
    check("tearfree ready after wrap", {31'b0, obs_ready}, 32'd1);

    // Full decode on the single-digit unit, one table entry per two frames
    cur_test = "decode";
    do_reset(1);
    run_frame(1, 16'h0000, 4'h0, 1'b0, 2, -1, 0, 0, -1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      load = 1'b1; value = {12'h000, vecs[i].nib}; dp_in = 4'h0;
      step();
      load = 1'b0;
      step();
      step();
      check($sformatf("decode %0h dead an", vecs[i].nib), {28'b0, obs_an}, 32'd1);
      step();
      check($sformatf("decode %0h hex0", vecs[i].nib), {25'b0, obs_hex}, {25'b0, vecs[i].hex});
      check($sformatf("decode %0h an", vecs[i].nib), {28'b0, obs_an}, 32'd0);
    end

    // Scan order, dead time and frame_done period without blanking
    cur_test = "scan";
    do_reset(2);
    run_frame(2, 16'h0000, 4'h0, 1'b0, 16, 3, 16'h1234, 4'h0, -1, 0, 0);
    run_frame(2, 16'h1234, 4'h0, 1'b1, 16, -1, 0, 0, -1, 0, 0);
    run_frame(2, 16'h1234, 4'h0, 1'b1, 16, -1, 0, 0, -1, 0, 0);

    // Active-high polarity with reset at d=2, tc=2 discarding a pending load
    cur_test = "midreset";
    do_reset(3);
    run_frame(3, 16'h0000, 4'h0, 1'b0, 10, 1, 16'h0777, 4'h2, -1, 0, 0);
    rst = 1'b1;
    sb.push_back(off_rec(3));
    step();
    check("midreset ready", {31'b0, obs_ready}, 32'd1);
    rst = 1'b0;
    run_frame(3, 16'h0000, 4'h0, 1'b0, 16, -1, 0, 0, -1, 0, 0);
    run_frame(3, 16'h0000, 4'h0, 1'b1, 16, -1, 0, 0, -1, 0, 0);

    if (sb.size() != 0) check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
